point_collector: RTL and testbench
==================================

// Module: point_collector
// PURPOSE
//  Upstream of the point-drawing stage. Per level, tracks which of the five
//  collectible points are still on the board and drives point_enable[4:0].
//  Clears a point when the player box overlaps it. Counts collected points
//  and flags level completion to the game controller.
// PARAMETERS
//  PLAYER_W  16  player box width, pixels
//  PLAYER_H  16  player box height, pixels
//  POINT_W   20  point box width, pixels
//  POINT_H   20  point box height, pixels
// PORTS
//  clk               in   1   pixel clock
//  rst               in   1   asynchronous reset, active-high
//  lvl               in   3   level select; valid levels are 1..3
//  level_start       in   1   one-cycle pulse; arms the level given by lvl
//  player_x          in   11  player box left edge
//  player_y          in   11  player box top edge
//  point_enable      out  5   bit i = point i+1 still present
//  points_collected  out  3   points taken in the current level (0..5)
//  collect_pulse     out  1   one-cycle pulse when >=1 point is taken
//  lvl_done          out  1   level-high once all five points are taken
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, lvl_q=0, hit_q=0.
//  Point table (x,y), indexed by lvl_q:
//   - lvl 1: (265,220) (515,120) (235,500) (310,460) (400,550)
//   - lvl 2 and lvl 3: all (0,0), placeholders
//  FSM states: IDLE, PLAY, DONE.
//   - level_start with lvl in 1..3 (any state): lvl_q<=lvl, point_enable<=5'h1F,
//     points_collected<=0, lvl_done<=0, hit_q<=0, go to PLAY.
//   - level_start with lvl 0 or 4..7: go to IDLE, point_enable<=0,
//     points_collected<=0, lvl_done<=0.
//   - PLAY with point_enable==0: go to DONE, lvl_done<=1. lvl_done holds
//     until the next level_start or rst.
//  lvl is sampled only on level_start. Changing lvl mid-level has no effect.
//  Overlap test, strict, using 12-bit sums to avoid overflow:
//   - px < ptx+POINT_W and px+PLAYER_W > ptx
//   - py < pty+POINT_H and py+PLAYER_H > pty
//  Pipeline, active in PLAY only:
//   - Cycle N: registered as hit_q[i] = overlap_i & point_enable[i].
//   - Cycle N+1: new = hit_q & point_enable.
//     point_enable <= point_enable & ~new.
//     points_collected += popcount(new).
//     collect_pulse <= |new.
//   - Total latency from position to cleared bit: 2 clocks.
//  Simultaneous hits: all bits clear in the same cycle; count adds the full
//   popcount; collect_pulse is a single cycle.
//  Player resting on a point: it is counted once, because the bit is already 0.
//  level_start on the same cycle as a hit: level_start wins, new is discarded.
//  In IDLE and DONE: hit_q is forced to 0 and collect_pulse stays 0.
//  points_collected saturates at 5. It is never decremented.
//  rst mid-level: immediate return to reset values, in IDLE.
// TESTING
//  1. rst; level_start lvl=1; player (270,225) -> 2 clk later point_enable=5'h1E,
//     collect_pulse=1 for 1 clk, points_collected=1.
//  2. Edge case, lvl=1, player_y=225: player_x=249 -> no hit; player_x=250 ->
//     bit0 clears. Likewise player_x=285 no hit, player_x=284 hit.
//  3. lvl=2, player (0,0) -> all five bits clear in one cycle,
//     points_collected=5, one collect_pulse, lvl_done=1 next clk.
//  4. lvl=1; visit all five points in turn, dwelling 10 clk on each ->
//     count 1..5, exactly 5 pulses, lvl_done=1; re-start -> enable=5'h1F, done=0.
//  5. Level started with lvl=5 -> IDLE, point_enable=0. Hold the player on a point
//     -> no pulse and no count.
//  6. Assert rst with 3 points taken -> all outputs 0 the same cycle.
//     Deassert, then level_start lvl=1 -> enable=5'h1F.

Source files
------------

// File: rtl/point_collector.sv
`default_nettype none
// ============================================================================
// Module   : point_collector
// Purpose  : Tracks the five collectible points of the active level, clears
//            each point the player box overlaps, and flags level completion.
// Revision : 1.0
// ============================================================================
module point_collector #(
    parameter int PLAYER_W = 16,
    parameter int PLAYER_H = 16,
    parameter int POINT_W  = 20,
    parameter int POINT_H  = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  lvl,
    input  logic        level_start,
    input  logic [10:0] player_x,
    input  logic [10:0] player_y,
    output logic [4:0]  point_enable,
    output logic [2:0]  points_collected,
    output logic        collect_pulse,
    output logic        lvl_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_max_points = 4'd5;

    state_t      state_q, state_d;
    logic [2:0]  lvl_q, lvl_d;
    logic [4:0]  hit_q, hit_d;
    logic [4:0]  point_enable_q, point_enable_d;
    logic [2:0]  points_collected_q, points_collected_d;
    logic        collect_pulse_q, collect_pulse_d;
    logic        lvl_done_q, lvl_done_d;

    logic [10:0] w_pt_x [5];
    logic [10:0] w_pt_y [5];
    logic [4:0]  w_overlap;
    logic [4:0]  w_new_hits;
    logic [2:0]  w_new_count;
    logic [3:0]  w_count_sum;
    logic [2:0]  w_count_sat;
    logic        w_lvl_valid;

    // Levels 2 and 3 are placeholders with every point at the origin.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            w_pt_x[i] = '0;
            w_pt_y[i] = '0;
        end
        if (lvl_q == 3'd1) begin
            w_pt_x[0] = 11'd265; w_pt_y[0] = 11'd220;
            w_pt_x[1] = 11'd515; w_pt_y[1] = 11'd120;
            w_pt_x[2] = 11'd235; w_pt_y[2] = 11'd500;
            w_pt_x[3] = 11'd310; w_pt_y[3] = 11'd460;
            w_pt_x[4] = 11'd400; w_pt_y[4] = 11'd550;
        end
    end

    // Strict box overlap; 12-bit sums keep edge-of-screen positions exact.
    always_comb begin
        w_overlap = '0;
        for (int i = 0; i < 5; i++) begin
            w_overlap[i] = ({1'b0, player_x} < ({1'b0, w_pt_x[i]} + 12'(POINT_W)))
                        && (({1'b0, player_x} + 12'(PLAYER_W)) > {1'b0, w_pt_x[i]})
                        && ({1'b0, player_y} < ({1'b0, w_pt_y[i]} + 12'(POINT_H)))
                        && (({1'b0, player_y} + 12'(PLAYER_H)) > {1'b0, w_pt_y[i]});
        end
    end

    always_comb begin
        w_new_hits  = hit_q & point_enable_q;
        w_new_count = '0;
        for (int i = 0; i < 5; i++) begin
            w_new_count = w_new_count + {2'b00, w_new_hits[i]};
        end
        w_count_sum = {1'b0, points_collected_q} + {1'b0, w_new_count};
        w_count_sat = (w_count_sum > c_max_points) ? c_max_points[2:0] : w_count_sum[2:0];
        w_lvl_valid = (lvl != 3'd0) && (lvl <= 3'd3);
    end

    always_comb begin
        state_d            = state_q;
        lvl_d              = lvl_q;
        hit_d              = hit_q;
        point_enable_d     = point_enable_q;
        points_collected_d = points_collected_q;
        collect_pulse_d    = 1'b0;
        lvl_done_d         = lvl_done_q;

        if (level_start) begin
            hit_d              = '0;
            points_collected_d = '0;
            lvl_done_d         = 1'b0;
            if (w_lvl_valid) begin
                state_d        = PLAY;
                lvl_d          = lvl;
                point_enable_d = 5'h1F;
            end else begin
                state_d        = IDLE;
                point_enable_d = '0;
            end
        end else begin
            case (state_q)
                PLAY: begin
                    hit_d              = w_overlap & point_enable_q;
                    point_enable_d     = point_enable_q & ~w_new_hits;
                    points_collected_d = w_count_sat;
                    collect_pulse_d    = |w_new_hits;
                    if (point_enable_q == 5'd0) begin
                        state_d    = DONE;
                        lvl_done_d = 1'b1;
                    end
                end
                default: begin
                    hit_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= IDLE;
            lvl_q              <= '0;
            hit_q              <= '0;
            point_enable_q     <= '0;
            points_collected_q <= '0;
            collect_pulse_q    <= 1'b0;
            lvl_done_q         <= 1'b0;
        end else begin
            state_q            <= state_d;
            lvl_q              <= lvl_d;
            hit_q              <= hit_d;
            point_enable_q     <= point_enable_d;
            points_collected_q <= points_collected_d;
            collect_pulse_q    <= collect_pulse_d;
            lvl_done_q         <= lvl_done_d;
        end
    end

    assign point_enable     = point_enable_q;
    assign points_collected = points_collected_q;
    assign collect_pulse    = collect_pulse_q;
    assign lvl_done         = lvl_done_q;

endmodule
`default_nettype wire

// File: tb/tb_point_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_point_collector
// Purpose  : Directed and randomized checks of point_collector against a
//            behavioural model of the level / collection rules.
// Revision : 1.0
// ============================================================================
module tb_point_collector;

    logic        clk;
    logic        rst;
    logic [2:0]  lvl;
    logic        level_start;
    logic [10:0] player_x;
    logic [10:0] player_y;
    logic [4:0]  point_enable;
    logic [2:0]  points_collected;
    logic        collect_pulse;
    logic        lvl_done;

    point_collector dut (
        .clk              (clk),
        .rst              (rst),
        .lvl              (lvl),
        .level_start      (level_start),
        .player_x         (player_x),
        .player_y         (player_y),
        .point_enable     (point_enable),
        .points_collected (points_collected),
        .collect_pulse    (collect_pulse),
        .lvl_done         (lvl_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vectors     = 0;
    int n_miscompares = 0;
    int n_pulses      = 0;

    int lvl1_x [5] = '{265, 515, 235, 310, 400};
    int lvl1_y [5] = '{220, 120, 500, 460, 550};

    // Reference model: mode 0 = idle, 1 = playing, 2 = level finished.
    int m_mode, m_lvl, m_en, m_cnt, m_done, m_pulse, m_seen;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int touching(input int lv, input int px, input int py);
        int mask = 0;
        for (int i = 0; i < 5; i++) begin
            int x = (lv == 1) ? lvl1_x[i] : 0;
            int y = (lv == 1) ? lvl1_y[i] : 0;
            if (px < x + 20 && px + 16 > x && py < y + 20 && py + 16 > y)
                mask |= (1 << i);
        end
        return mask;
    endfunction

    function automatic int ones(input int v);
        int n = 0;
        for (int i = 0; i < 5; i++) n += (v >> i) & 1;
        return n;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_lvl = 0; m_en = 0; m_cnt = 0; m_done = 0; m_pulse = 0; m_seen = 0;
    endtask

    // One clock of the collection rules; m_seen holds the points touched
    // one clock ago, which are taken on this clock if still on the board.
    task automatic model_clock();
        int taken;
        m_pulse = 0;
        if (level_start) begin
            m_cnt = 0; m_done = 0; m_seen = 0;
            if (lvl >= 1 && lvl <= 3) begin
                m_mode = 1; m_lvl = int'(lvl); m_en = 31;
            end else begin
                m_mode = 0; m_en = 0;
            end
        end else if (m_mode == 1) begin
            taken   = m_seen & m_en;
            m_seen  = touching(m_lvl, int'(player_x), int'(player_y)) & m_en;
            if (m_en == 0) begin
                m_mode = 2; m_done = 1;
            end
            m_en    = m_en & ~taken;
            m_cnt   = (m_cnt + ones(taken) > 5) ? 5 : m_cnt + ones(taken);
            m_pulse = (taken != 0);
        end else begin
            m_seen = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".enable"}, int'(point_enable), m_en);
        check_eq({tag, ".count"},  int'(points_collected), m_cnt);
        check_eq({tag, ".pulse"},  int'(collect_pulse), m_pulse);
        check_eq({tag, ".done"},   int'(lvl_done), m_done);
    endtask

    task automatic step(input string tag, input logic ls, input logic [2:0] lv,
                        input int px, input int py);
        @(negedge clk);
        level_start = ls;
        lvl         = lv;
        player_x    = px[10:0];
        player_y    = py[10:0];
        @(posedge clk);
        model_clock();
        #1;
        compare_all(tag);
        if (collect_pulse) n_pulses++;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        level_start = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int edge_px [4] = '{249, 250, 285, 284};
        int k, px, py;
        logic ls;
        logic [2:0] lv;

        rst = 1'b1; level_start = 1'b0; lvl = 3'd0; player_x = '0; player_y = '0;
        model_reset();
        #1;
        compare_all("reset");
        do_reset("reset2");

        // First collection on level 1
        step("start1", 1'b1, 3'd1, 270, 225);
        repeat (4) step("hit1", 1'b0, 3'd1, 270, 225);
        check_eq("hit1.enable_final", int'(point_enable), 30);

        // Overlap boundaries on point 1
        for (int i = 0; i < 4; i++) begin
            step("edge_start", 1'b1, 3'd1, 0, 0);
            repeat (4) step("edge", 1'b0, 3'd1, edge_px[i], 225);
            check_eq("edge.bit0", int'(point_enable[0]),
                     (edge_px[i] == 250 || edge_px[i] == 284) ? 0 : 1);
        end

        // All five level-2 points taken at once
        n_pulses = 0;
        step("lvl2_start", 1'b1, 3'd2, 0, 0);
        repeat (6) step("lvl2", 1'b0, 3'd1, 0, 0);
        check_eq("lvl2.pulses", n_pulses, 1);
        check_eq("lvl2.done", int'(lvl_done), 1);

        // Walk through every level-1 point; lvl input wanders mid-level
        n_pulses = 0;
        step("walk_start", 1'b1, 3'd1, 1000, 1000);
        for (int i = 0; i < 5; i++)
            repeat (10) step("walk", 1'b0, 3'(i + 2), lvl1_x[i] + 5, lvl1_y[i] + 5);
        repeat (3) step("walk_end", 1'b0, 3'd0, 1000, 1000);
        check_eq("walk.pulses", n_pulses, 5);
        check_eq("walk.count", int'(points_collected), 5);
        check_eq("walk.done", int'(lvl_done), 1);
        step("restart", 1'b1, 3'd1, 1000, 1000);
        check_eq("restart.enable", int'(point_enable), 31);
        check_eq("restart.done", int'(lvl_done), 0);

        // Invalid level parks in idle and ignores the player
        n_pulses = 0;
        step("bad_start", 1'b1, 3'd5, 270, 225);
        repeat (6) step("bad", 1'b0, 3'd1, 270, 225);
        check_eq("bad.pulses", n_pulses, 0);
        check_eq("bad.enable", int'(point_enable), 0);

        // Reset after three points
        step("rst_start", 1'b1, 3'd1, 1000, 1000);
        for (int i = 0; i < 3; i++)
            repeat (4) step("rst_walk", 1'b0, 3'd1, lvl1_x[i] + 5, lvl1_y[i] + 5);
        check_eq("rst.count3", int'(points_collected), 3);
        do_reset("rst_mid");
        step("rst_restart", 1'b1, 3'd1, 1000, 1000);
        check_eq("rst_restart.enable", int'(point_enable), 31);

        // Randomized play
        for (int n = 0; n < 2000; n++) begin
            ls = ($urandom_range(0, 39) == 0);
            lv = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(1, 3)) : 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: begin px = $urandom_range(0, 2047); py = $urandom_range(0, 2047); end
                1: begin px = $urandom_range(0, 30);   py = $urandom_range(0, 30);   end
                default: begin
                    k  = $urandom_range(0, 4);
                    px = lvl1_x[k] + $urandom_range(0, 50) - 25;
                    py = lvl1_y[k] + $urandom_range(0, 50) - 25;
                end
            endcase
            step("rand", ls, lv, px, py);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
